// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the RV32I multicycle control FSM.
// Contents: major opcode values, the ALU operation class, FSM state encoding,
// datapath mux select encodings and the per-cycle control bundle.
package multicycle_controller_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        FORCE_ADD        = 2'd0,
        FORCE_SUB        = 2'd1,
        CHECK_FUNCT_CODE = 2'd2,
        I_TYPE_MATH      = 2'd3
    } alu_op_t;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
        StJalr,
        StUpper,
        StFault
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ASelPc    = 2'd0,
        ASelOldPc = 2'd1,
        ASelRs1   = 2'd2,
        ASelZero  = 2'd3
    } a_sel_t;

    typedef enum logic [1:0] {
        BSelRs2  = 2'd0,
        BSelImm  = 2'd1,
        BSelFour = 2'd2
    } b_sel_t;

    typedef enum logic [1:0] {
        ResAluOut    = 2'd0,
        ResMemData   = 2'd1,
        ResAluResult = 2'd2
    } result_sel_t;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        adr_src;
        logic        ir_write;
        logic        pc_write;
        logic        reg_write;
        a_sel_t      alu_src_a;
        b_sel_t      alu_src_b;
        result_sel_t result_src;
        alu_op_t     alu_op;
        logic        fault;
    } ctrl_t;

    // States that hold a memory request open until mem_ready.
    function automatic logic is_wait_state(ctrl_state_t s);
        return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
    endfunction

endpackage

// File: rtl/multicycle_controller_ctrl_output_decode.sv
// Per-state control decode for the multicycle controller.
// Ports:
//   state        - current FSM state
//   opcode       - instr[6:0], selects LUI vs AUIPC operand A in UPPER
//   branch_taken - gates pc_write in BRANCH
//   mem_ready    - gates ir_write/pc_write in FETCH
//   ctrl         - control bundle for this cycle
module multicycle_controller_ctrl_output_decode
    import multicycle_controller_pkg::*;
(
    input  ctrl_state_t state,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl            = '0;
        ctrl.alu_src_a  = ASelPc;
        ctrl.alu_src_b  = BSelRs2;
        ctrl.result_src = ResAluOut;
        ctrl.alu_op     = FORCE_ADD;

        unique case (state)
            StFetch: begin
                // PC+4 goes straight from the ALU onto the result bus.
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = ASelPc;
                ctrl.alu_src_b  = BSelFour;
                ctrl.result_src = ResAluResult;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_write   = mem_ready;
            end
            StDecode: begin
                // Precompute oldPC+imm so BRANCH/JAL find the target in ALUOut.
                ctrl.alu_src_a = ASelOldPc;
                ctrl.alu_src_b = BSelImm;
            end
            StMemAdr: begin
                ctrl.alu_src_a = ASelRs1;
                ctrl.alu_src_b = BSelImm;
            end
            StMemRead: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
            end
            StMemWb: begin
                ctrl.result_src = ResMemData;
                ctrl.reg_write  = 1'b1;
            end
            StMemWrite: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.adr_src = 1'b1;
            end
            StExecR: begin
                ctrl.alu_src_a = ASelRs1;
                ctrl.alu_src_b = BSelRs2;
                ctrl.alu_op    = CHECK_FUNCT_CODE;
            end
            StExecI: begin
                ctrl.alu_src_a = ASelRs1;
                ctrl.alu_src_b = BSelImm;
                ctrl.alu_op    = I_TYPE_MATH;
            end
            StAluWb: begin
                ctrl.result_src = ResAluOut;
                ctrl.reg_write  = 1'b1;
            end
            StBranch: begin
                // ALUOut still holds the target computed in DECODE.
                ctrl.alu_src_a  = ASelRs1;
                ctrl.alu_src_b  = BSelRs2;
                ctrl.alu_op     = FORCE_SUB;
                ctrl.result_src = ResAluOut;
                ctrl.pc_write   = branch_taken;
            end
            StJalr: begin
                ctrl.alu_src_a = ASelRs1;
                ctrl.alu_src_b = BSelImm;
            end
            StJal: begin
                // Jump to ALUOut while the ALU forms the link value oldPC+4.
                ctrl.result_src = ResAluOut;
                ctrl.pc_write   = 1'b1;
                ctrl.alu_src_a  = ASelOldPc;
                ctrl.alu_src_b  = BSelFour;
            end
            StUpper: begin
                ctrl.alu_src_a = (opcode == OP_LUI) ? ASelZero : ASelOldPc;
                ctrl.alu_src_b = BSelImm;
            end
            StFault: begin
                ctrl.fault = 1'b1;
            end
            default: begin
                ctrl.fault = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences register file, immediate generator,
// ALU and a unified instruction/data memory port.
// Ports:
//   clk, reset (sync, active-low)
//   opcode, branch_taken, mem_ready           - inputs from IR, comparator, memory
//   mem_req, mem_we, adr_src                  - memory handshake and address select
//   ir_write, pc_write, reg_write             - architectural write enables
//   alu_src_a, alu_src_b, result_src, alu_op  - datapath selects / ALU class
//   fault                                     - sticky fault (illegal opcode or timeout)
//   instret                                   - retired-instruction counter
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned INSTRET_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 branch_taken,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           result_src,
    output alu_op_t              alu_op,
    output logic                 fault,
    output logic [INSTRET_W-1:0] instret
);

    // The counter never needs to hold more than TIMEOUT_CYCLES-1: the cycle
    // that would reach TIMEOUT_CYCLES leaves the state instead.
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] TimeoutLast =
        CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    ctrl_state_t          state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 timeout_hit;
    ctrl_t                ctrl;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TimeoutLast);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (timeout_hit) begin
                    state_d = StFault;
                end
            end
            StDecode: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = StMemAdr;
                    OP_R:              state_d = StExecR;
                    OP_I:              state_d = StExecI;
                    OP_BRANCH:         state_d = StBranch;
                    OP_JAL:            state_d = StJal;
                    OP_JALR:           state_d = StJalr;
                    OP_LUI, OP_AUIPC:  state_d = StUpper;
                    default:           state_d = StFault;
                endcase
            end
            StMemAdr:   state_d = (opcode == OP_STORE) ? StMemWrite : StMemRead;
            StMemRead: begin
                if (mem_ready) begin
                    state_d = StMemWb;
                end else if (timeout_hit) begin
                    state_d = StFault;
                end
            end
            StMemWb:    state_d = StFetch;
            StMemWrite: begin
                if (mem_ready) begin
                    state_d = StFetch;
                end else if (timeout_hit) begin
                    state_d = StFault;
                end
            end
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StJalr:     state_d = StJal;
            StJal:      state_d = StAluWb;
            StUpper:    state_d = StAluWb;
            StFault:    state_d = StFault;
            default:    state_d = StFault;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if ((TIMEOUT_CYCLES != 0) && (state_d == state_q) && is_wait_state(state_q) &&
            !mem_ready) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Retirement is any arrival at FETCH from elsewhere; FAULT never gets there.
    always_comb begin
        instret_d = instret_q;
        if ((state_d == StFetch) && (state_q != StFetch)) begin
            instret_d = instret_q + INSTRET_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StFetch;
            cnt_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            instret_q <= instret_d;
        end
    end

    multicycle_controller_ctrl_output_decode u_output_decode (
        .state        (state_q),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .ctrl         (ctrl)
    );

    assign mem_req    = ctrl.mem_req;
    assign mem_we     = ctrl.mem_we;
    assign adr_src    = ctrl.adr_src;
    assign ir_write   = ctrl.ir_write;
    assign pc_write   = ctrl.pc_write;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign result_src = ctrl.result_src;
    assign alu_op     = ctrl.alu_op;
    assign fault      = ctrl.fault;
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Each cycle the full output vector
// is compared against a hand-written per-state signature.
// Signature bits: mem_req mem_we adr_src | ir_write pc_write reg_write |
//                 a[1:0] | b[1:0] | result[1:0] | alu_op[1:0] | fault
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    localparam logic [14:0] S_FETCH_W  = 15'b100_000_00_10_10_00_0;
    localparam logic [14:0] S_FETCH_R  = 15'b100_110_00_10_10_00_0;
    localparam logic [14:0] S_DECODE   = 15'b000_000_01_01_00_00_0;
    localparam logic [14:0] S_MEMADR   = 15'b000_000_10_01_00_00_0;
    localparam logic [14:0] S_MEMREAD  = 15'b101_000_00_00_00_00_0;
    localparam logic [14:0] S_MEMWB    = 15'b000_001_00_00_01_00_0;
    localparam logic [14:0] S_MEMWRITE = 15'b111_000_00_00_00_00_0;
    localparam logic [14:0] S_EXECR    = 15'b000_000_10_00_00_10_0;
    localparam logic [14:0] S_EXECI    = 15'b000_000_10_01_00_11_0;
    localparam logic [14:0] S_ALUWB    = 15'b000_001_00_00_00_00_0;
    localparam logic [14:0] S_BR_NT    = 15'b000_000_10_00_00_01_0;
    localparam logic [14:0] S_BR_T     = 15'b000_010_10_00_00_01_0;
    localparam logic [14:0] S_JALR     = 15'b000_000_10_01_00_00_0;
    localparam logic [14:0] S_JAL      = 15'b000_010_01_10_00_00_0;
    localparam logic [14:0] S_LUI      = 15'b000_000_11_01_00_00_0;
    localparam logic [14:0] S_AUIPC    = 15'b000_000_01_01_00_00_0;
    localparam logic [14:0] S_FAULT    = 15'b000_000_00_00_00_00_1;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    alu_op_t     alu_op;
    logic        fault;
    logic [31:0] instret;
    logic [14:0] sig;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_instret = 32'd0;

    always #5 clk = ~clk;

    multicycle_controller #(
        .TIMEOUT_CYCLES (4),
        .INSTRET_W      (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .adr_src      (adr_src),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .result_src   (result_src),
        .alu_op       (alu_op),
        .fault        (fault),
        .instret      (instret)
    );

    assign sig = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, result_src, alu_op, fault};

    // Time convention: tasks are entered 1 ns after a rising edge; inputs are
    // set then, outputs are sampled 4 ns later (mid-cycle).

    task automatic test_reset();
        reset = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        #4;
        total++;
        if (sig !== S_FETCH_W) begin
            bad++;
            $display("FAIL reset_outputs: got %b want %b", sig, S_FETCH_W);
        end
        total++;
        if (instret !== 32'd0) begin
            bad++;
            $display("FAIL reset_instret: got %0d want 0", instret);
        end
        total++;
        if (fault !== 1'b0) begin
            bad++;
            $display("FAIL reset_fault: got %b want 0", fault);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_r_type();
        logic [14:0] exp [4] = '{S_FETCH_R, S_DECODE, S_EXECR, S_ALUWB};
        opcode = 7'b0110011;
        mem_ready = 1'b1;
        branch_taken = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #4;
            total++;
            if (sig !== exp[i]) begin
                bad++;
                $display("FAIL r_type cyc%0d: got %b want %b", i, sig, exp[i]);
            end
            @(posedge clk);
            #1;
        end
        exp_instret++;
        total++;
        if (instret !== exp_instret) begin
            bad++;
            $display("FAIL r_type_instret: got %0d want %0d", instret, exp_instret);
        end
    endtask

    task automatic test_load_wait();
        logic [14:0] exp [8] = '{S_FETCH_R, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMREAD,
                                 S_MEMREAD, S_MEMREAD, S_MEMWB};
        logic        rdy [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        opcode = 7'b0000011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #4;
            total++;
            if (sig !== exp[i]) begin
                bad++;
                $display("FAIL load_wait cyc%0d: got %b want %b", i, sig, exp[i]);
            end
            @(posedge clk);
            #1;
        end
        exp_instret++;
        total++;
        if (instret !== exp_instret) begin
            bad++;
            $display("FAIL load_instret: got %0d want %0d", instret, exp_instret);
        end
    endtask

    task automatic test_branch();
        // branch_taken is deliberately high outside BRANCH in the not-taken run.
        logic [14:0] exp [6] = '{S_FETCH_R, S_DECODE, S_BR_NT, S_FETCH_R, S_DECODE, S_BR_T};
        logic        bt  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode = 7'b1100011;
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            branch_taken = bt[i];
            #4;
            total++;
            if (sig !== exp[i]) begin
                bad++;
                $display("FAIL branch cyc%0d: got %b want %b", i, sig, exp[i]);
            end
            @(posedge clk);
            #1;
        end
        branch_taken = 1'b0;
        exp_instret += 2;
        total++;
        if (instret !== exp_instret) begin
            bad++;
            $display("FAIL branch_instret: got %0d want %0d", instret, exp_instret);
        end
    endtask

    task automatic test_jumps();
        logic [14:0] exp [9] = '{S_FETCH_R, S_DECODE, S_JALR, S_JAL, S_ALUWB,
                                 S_FETCH_R, S_DECODE, S_JAL, S_ALUWB};
        logic [6:0]  op  [9] = '{7'b1100111, 7'b1100111, 7'b1100111, 7'b1100111, 7'b1100111,
                                 7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111};
        mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            opcode = op[i];
            #4;
            total++;
            if (sig !== exp[i]) begin
                bad++;
                $display("FAIL jumps cyc%0d: got %b want %b", i, sig, exp[i]);
            end
            @(posedge clk);
            #1;
        end
        exp_instret += 2;
        total++;
        if (instret !== exp_instret) begin
            bad++;
            $display("FAIL jumps_instret: got %0d want %0d", instret, exp_instret);
        end
    endtask

    task automatic test_imm_upper_store();
        logic [14:0] exp [16] = '{S_FETCH_R, S_DECODE, S_EXECI, S_ALUWB,
                                  S_FETCH_R, S_DECODE, S_LUI, S_ALUWB,
                                  S_FETCH_R, S_DECODE, S_AUIPC, S_ALUWB,
                                  S_FETCH_R, S_DECODE, S_MEMADR, S_MEMWRITE};
        logic [6:0]  op  [4]  = '{7'b0010011, 7'b0110111, 7'b0010111, 7'b0100011};
        mem_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            opcode = op[i / 4];
            #4;
            total++;
            if (sig !== exp[i]) begin
                bad++;
                $display("FAIL imm_upper_store cyc%0d: got %b want %b", i, sig, exp[i]);
            end
            @(posedge clk);
            #1;
        end
        exp_instret += 4;
        total++;
        if (instret !== exp_instret) begin
            bad++;
            $display("FAIL imm_upper_store_instret: got %0d want %0d", instret, exp_instret);
        end
    endtask

    task automatic test_illegal();
        logic [14:0] exp [6] = '{S_FETCH_R, S_DECODE, S_FAULT, S_FAULT, S_FAULT, S_FAULT};
        logic        rdy [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        opcode = 7'b1111111;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy[i];
            #4;
            total++;
            if (sig !== exp[i]) begin
                bad++;
                $display("FAIL illegal cyc%0d: got %b want %b", i, sig, exp[i]);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (instret !== exp_instret) begin
            bad++;
            $display("FAIL illegal_instret_frozen: got %0d want %0d", instret, exp_instret);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        mem_ready = 1'b0;
        exp_instret = 32'd0;
        #4;
        total++;
        if (sig !== S_FETCH_W) begin
            bad++;
            $display("FAIL illegal_reset_state: got %b want %b", sig, S_FETCH_W);
        end
        total++;
        if (instret !== exp_instret) begin
            bad++;
            $display("FAIL illegal_reset_instret: got %0d want 0", instret);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        logic [14:0] exp_a [8] = '{S_FETCH_R, S_DECODE, S_MEMADR, S_MEMWRITE, S_MEMWRITE,
                                   S_MEMWRITE, S_MEMWRITE, S_FAULT};
        logic [14:0] exp_b [8] = '{S_FETCH_R, S_DECODE, S_MEMADR, S_MEMWRITE, S_MEMWRITE,
                                   S_MEMWRITE, S_MEMWRITE, S_FETCH_W};
        logic        rdy_b [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [14:0] exp_c [5] = '{S_FETCH_R, S_DECODE, S_MEMADR, S_MEMWRITE, S_FETCH_W};
        logic        rst_c [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        opcode = 7'b0100011;
        // Ready held low: fourth MEMWRITE wait cycle exhausts the budget.
        for (int i = 0; i < 8; i++) begin
            mem_ready = (i == 0);
            #4;
            total++;
            if (sig !== exp_a[i]) begin
                bad++;
                $display("FAIL timeout_fault cyc%0d: got %b want %b", i, sig, exp_a[i]);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_instret = 32'd0;
        // Ready arrives in the very cycle the budget would expire.
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy_b[i];
            #4;
            total++;
            if (sig !== exp_b[i]) begin
                bad++;
                $display("FAIL timeout_race cyc%0d: got %b want %b", i, sig, exp_b[i]);
            end
            @(posedge clk);
            #1;
        end
        exp_instret++;
        total++;
        if (instret !== exp_instret) begin
            bad++;
            $display("FAIL timeout_race_instret: got %0d want %0d", instret, exp_instret);
        end
        // Reset in the middle of a store handshake.
        for (int i = 0; i < 5; i++) begin
            reset = rst_c[i];
            mem_ready = (i == 0);
            #4;
            total++;
            if (sig !== exp_c[i]) begin
                bad++;
                $display("FAIL reset_mid_store cyc%0d: got %b want %b", i, sig, exp_c[i]);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        total++;
        if (instret !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_store_instret: got %0d want 0", instret);
        end
    endtask

    initial begin
        reset = 1'b0;
        opcode = 7'd0;
        branch_taken = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_r_type();
        test_load_wait();
        test_branch();
        test_jumps();
        test_imm_upper_store();
        test_illegal();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
